// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, opcodes and state type for the RV32M multiply/divide sequencer
//
// Contents:
//   XLEN        operand/result width (32 only)
//   DIV_ITERS   restoring-divide iteration count
//   OP_*        RV32M funct3 encodings
//   state_t     sequencer state enum
//   magnitude() two's-complement absolute value, applied only for signed ops
package muldiv_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one combinational restoring-division iteration
//
// Ports:
//   i_rem  partial remainder (always < divisor, or dividend prefix when divisor is 0)
//   i_quo  shift register: unconsumed dividend bits above, quotient bits below
//   i_div  divisor magnitude
//   o_rem  next partial remainder
//   o_quo  i_quo shifted left with the new quotient bit in bit 0
module muldiv_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);
    logic [W:0]   w_trial;
    logic [W-1:0] w_diff;
    logic         w_fits;

    // Bring the next dividend bit into the remainder and try a subtraction.
    assign w_trial = {i_rem, i_quo[W-1]};
    assign w_fits  = (w_trial >= {1'b0, i_div});
    // When the subtraction fits the true difference is below the divisor,
    // so the low W bits of the trial minus divisor are exact.
    assign w_diff  = w_trial[W-1:0] - i_div;
    assign o_rem   = w_fits ? w_diff : w_trial[W-1:0];
    assign o_quo   = {i_quo[W-2:0], w_fits};

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M multiply/divide sequencer (1-cycle multiply, 32-cycle restoring divide)
//
// Optional feature macro: MULDIV_DIV_EARLY_OUT_EN (divide-by-zero skips the iteration loop)
//
// Ports:
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_req_valid / o_req_ready   request handshake; i_req_op (funct3), i_req_a, i_req_b, i_req_tag
//   i_kill                      abandon the in-flight operation / pending response
//   o_resp_valid / i_resp_ready response handshake; o_resp_data, o_resp_tag held until taken
//   o_busy                      sequencer not idle
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [2:0]       i_req_op,
    input  logic [XLEN-1:0]  i_req_a,
    input  logic [XLEN-1:0]  i_req_b,
    input  logic [TAG_W-1:0] i_req_tag,
    input  logic             i_kill,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic [XLEN-1:0]  o_resp_data,
    output logic [TAG_W-1:0] o_resp_tag,
    output logic             o_busy
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   r_resp_data;
    logic [TAG_W-1:0]  r_tag;
    logic [TAG_W-1:0]  r_resp_tag;
    logic              r_resp_valid;
    logic [5:0]        r_cnt;

    logic              w_accept;
    logic [XLEN-1:0]   w_step_rem;
    logic [XLEN-1:0]   w_step_quo;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic              w_div_signed;
    logic              w_q_neg;
    logic              w_r_neg;
    logic [XLEN-1:0]   w_div_res;

    assign o_req_ready  = (r_state == ST_IDLE) & ~i_kill;
    assign w_accept     = i_req_valid & o_req_ready;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_tag   = r_resp_tag;

    // Operands are extended to 64 bits by their signedness; the low 64 bits
    // of that product equal the low 64 bits of the 33x33 signed product.
    assign w_a_sgn   = ((r_op == OP_MULH) || (r_op == OP_MULHSU)) & r_a[XLEN-1];
    assign w_b_sgn   = (r_op == OP_MULH) & r_b[XLEN-1];
    assign w_a_ext   = {{XLEN{w_a_sgn}}, r_a};
    assign w_b_ext   = {{XLEN{w_b_sgn}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // Sign fix-up on the magnitude results. A zero divisor leaves the
    // all-ones quotient untouched, and the negated remainder magnitude
    // reproduces the original dividend.
    assign w_div_signed = (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_q_neg      = w_div_signed & (r_a[XLEN-1] ^ r_b[XLEN-1]) & (r_b != '0);
    assign w_r_neg      = w_div_signed & r_a[XLEN-1];
    assign w_div_res    = ((r_op == OP_REM) || (r_op == OP_REMU))
                        ? (w_r_neg ? -r_rem : r_rem)
                        : (w_q_neg ? -r_quo : r_quo);

    muldiv_div_step #(.W(XLEN)) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!i_req_op[2]) begin
                        w_state_nxt = ST_MUL;
                    end else begin
`ifdef MULDIV_DIV_EARLY_OUT_EN
                        w_state_nxt = (i_req_b == '0) ? ST_FIX : ST_DIV;
`else
                        w_state_nxt = ST_DIV;
`endif
                    end
                end
            end
            ST_MUL:  w_state_nxt = ST_DONE;
            ST_DIV:  if (r_cnt == 6'(DIV_ITERS - 1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: if (r_resp_valid && i_resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // Kill overrides everything, including a simultaneous response handshake.
        if (i_kill && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvs        <= '0;
            r_result     <= '0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= i_req_op;
                        r_a   <= i_req_a;
                        r_b   <= i_req_b;
                        r_tag <= i_req_tag;
                        r_cnt <= '0;
                        r_rem <= '0;
                        // funct3 bit 0 clear marks the signed divide variants.
                        r_quo <= magnitude(i_req_a, ~i_req_op[0]);
                        r_dvs <= magnitude(i_req_b, ~i_req_op[0]);
`ifdef MULDIV_DIV_EARLY_OUT_EN
                        // Preload what 32 iterations against a zero divisor would leave.
                        if (i_req_op[2] && (i_req_b == '0)) begin
                            r_quo <= '1;
                            r_rem <= magnitude(i_req_a, ~i_req_op[0]);
                        end
`endif
                    end
                end
                ST_MUL: r_result <= w_mul_res;
                ST_DIV: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt + 6'd1;
                end
                ST_FIX: r_result <= w_div_res;
                ST_DONE: begin
                    if (i_kill) begin
                        r_resp_valid <= 1'b0;
                    end else if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_result;
                        r_resp_tag   <= r_tag;
                    end else if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard testbench for muldiv_sequencer
module tb_muldiv_sequencer;

`ifdef MULDIV_DIV_EARLY_OUT_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [36:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32), .TAG_W(5)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_tag    (req_tag),
        .i_kill       (kill),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_data  (resp_data),
        .o_resp_tag   (resp_tag),
        .o_busy       (busy)
    );

    // Reference model built on simulator 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 0) return DIV0_LAT;
        return 34;
    endfunction

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (req_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL req_ready_timeout: req_ready=%b, want 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Called one step after the accept edge; lat = edges until resp_valid seen.
    task automatic collect(output bit got, output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        got = (resp_valid === 1'b1);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        total++; if (resp_tag !== 5'h0) begin bad++; $display("FAIL reset_resp_tag: got %h want 0", resp_tag); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_mulh_corner();
        bit got; int lat; logic [36:0] e;
        sb_q.push_back({5'd17, 32'h4000_0000});
        drive_req(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd17);
        collect(got, lat);
        e = sb_q.pop_front();
        total++;
        if (!got || lat != 2 || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
            bad++;
            $display("FAIL mulh_corner: got valid=%b lat=%0d data=%h tag=%h, want lat=2 data=%h tag=%h",
                     got, lat, resp_data, resp_tag, e[31:0], e[36:32]);
        end
        handshake();
    endtask

    task automatic test_mul();
        logic [31:0] pa[4] = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1234_5678};
        logic [31:0] pb[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h9ABC_DEF0};
        bit got; int lat; logic [36:0] e;
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 4; k++) begin
                sb_q.push_back({5'(op * 4 + k), model(3'(op), pa[k], pb[k])});
                drive_req(3'(op), pa[k], pb[k], 5'(op * 4 + k));
                collect(got, lat);
                e = sb_q.pop_front();
                total++;
                if (!got || lat != 2 || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
                    bad++;
                    $display("FAIL mul op=%0d a=%h b=%h: got valid=%b lat=%0d data=%h tag=%h, want lat=2 data=%h tag=%h",
                             op, pa[k], pb[k], got, lat, resp_data, resp_tag, e[31:0], e[36:32]);
                end
                handshake();
            end
        end
    endtask

    task automatic test_div_corner();
        logic [2:0]  ops[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] bs[8]  = '{32'd2, 32'd2, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] rs[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                                32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        bit got; int lat; logic [36:0] e;
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back({5'(k + 3), rs[k]});
            drive_req(ops[k], as[k], bs[k], 5'(k + 3));
            collect(got, lat);
            e = sb_q.pop_front();
            total++;
            if (!got || lat != exp_lat(ops[k], bs[k]) || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
                bad++;
                $display("FAIL div_corner op=%0d a=%h b=%h: got valid=%b lat=%0d data=%h tag=%h, want lat=%0d data=%h tag=%h",
                         ops[k], as[k], bs[k], got, lat, resp_data, resp_tag,
                         exp_lat(ops[k], bs[k]), e[31:0], e[36:32]);
            end
            handshake();
        end
    endtask

    task automatic test_div_random();
        logic [2:0] op; logic [31:0] a, b;
        bit got; int lat; logic [36:0] e;
        for (int k = 0; k < 12; k++) begin
            op = 3'(4 + (k % 4));
            a  = $urandom;
            b  = (k % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (k % 5 == 1) b = -b;
            sb_q.push_back({5'(k), model(op, a, b)});
            drive_req(op, a, b, 5'(k));
            collect(got, lat);
            e = sb_q.pop_front();
            total++;
            if (!got || lat != exp_lat(op, b) || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
                bad++;
                $display("FAIL div_random op=%0d a=%h b=%h: got valid=%b lat=%0d data=%h tag=%h, want lat=%0d data=%h tag=%h",
                         op, a, b, got, lat, resp_data, resp_tag, exp_lat(op, b), e[31:0], e[36:32]);
            end
            handshake();
        end
    endtask

    task automatic test_kill();
        bit got; bit seen; int lat; logic [36:0] e;
        drive_req(3'd4, 32'd1000, 32'd7, 5'd1);
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL kill_div_req_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        kill = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_div_busy: got %b want 0", busy); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen |= resp_valid; end
        total++; if (seen) begin bad++; $display("FAIL kill_div_no_resp: resp_valid seen=1 want 0"); end
        sb_q.push_back({5'd2, model(3'd0, 32'd12, 32'd13)});
        drive_req(3'd0, 32'd12, 32'd13, 5'd2);
        collect(got, lat);
        e = sb_q.pop_front();
        total++;
        if (!got || lat != 2 || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
            bad++;
            $display("FAIL kill_then_mul: got valid=%b lat=%0d data=%h tag=%h, want lat=2 data=%h tag=%h",
                     got, lat, resp_data, resp_tag, e[31:0], e[36:32]);
        end
        handshake();
        // Kill while idle blocks acceptance.
        kill = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 32'd1; req_b = 32'd1; req_tag = 5'd9;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL kill_idle_req_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        kill = 1'b0; req_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_idle_accepted: busy=%b want 0", busy); end
        // Kill together with resp_ready in DONE drops the response.
        drive_req(3'd3, 32'hFFFF_0000, 32'h0001_0000, 5'd4);
        collect(got, lat);
        total++; if (!got) begin bad++; $display("FAIL kill_done_setup: resp_valid=0 want 1"); end
        kill = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; resp_ready = 1'b0;
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL kill_done: resp_valid=%b busy=%b want 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit got; bit seen; int lat; logic [36:0] e;
        drive_req(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd6);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid_state: busy=%b resp_valid=%b req_ready=%b want 0 0 1", busy, resp_valid, req_ready);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen |= resp_valid; end
        total++; if (seen) begin bad++; $display("FAIL reset_mid_no_resp: resp_valid seen=1 want 0"); end
        sb_q.push_back({5'd7, model(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF)});
        drive_req(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd7);
        collect(got, lat);
        e = sb_q.pop_front();
        total++;
        if (!got || lat != 2 || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
            bad++;
            $display("FAIL reset_then_mul: got valid=%b lat=%0d data=%h tag=%h, want lat=2 data=%h tag=%h",
                     got, lat, resp_data, resp_tag, e[31:0], e[36:32]);
        end
        handshake();
    endtask

    task automatic test_hold();
        bit got; bit ok; int lat; logic [36:0] e;
        sb_q.push_back({5'd21, model(3'd3, 32'hFFFF_FFFF, 32'h0000_0002)});
        drive_req(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd21);
        collect(got, lat);
        e = sb_q.pop_front();
        ok = got;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid !== 1'b1 || resp_data !== e[31:0] || resp_tag !== e[36:32] || req_ready !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (!ok || resp_valid !== 1'b1 || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
            bad++;
            $display("FAIL hold_stable: valid=%b data=%h tag=%h req_ready=%b, want 1 %h %h 0",
                     resp_valid, resp_data, resp_tag, req_ready, e[31:0], e[36:32]);
        end
        handshake();
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release: resp_valid=%b busy=%b req_ready=%b want 0 0 1", resp_valid, busy, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op; logic [31:0] a, b;
        bit got; int lat; logic [36:0] e;
        for (int k = 0; k < 8; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (k == 3) ? 32'd0 : $urandom;
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d: got %b want 1", k, req_ready); end
            sb_q.push_back({5'(k + 24), model(op, a, b)});
            drive_req(op, a, b, 5'(k + 24));
            collect(got, lat);
            e = sb_q.pop_front();
            total++;
            if (!got || lat != exp_lat(op, b) || resp_data !== e[31:0] || resp_tag !== e[36:32]) begin
                bad++;
                $display("FAIL b2b op=%0d a=%h b=%h: got valid=%b lat=%0d data=%h tag=%h, want lat=%0d data=%h tag=%h",
                         op, a, b, got, lat, resp_data, resp_tag, exp_lat(op, b), e[31:0], e[36:32]);
            end
            handshake();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        kill = 1'b0; resp_ready = 1'b0;
        test_reset();
        test_mulh_corner();
        test_mul();
        test_div_corner();
        test_div_random();
        test_kill();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: %0d entries, want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 Parameter TAG_W, default 5, destination-register tag width.
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when both high.
REQ-007 req_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 req_a, req_b  input  XLEN each  rs1, rs2 operands.
REQ-009 req_tag  input  TAG_W  returned unchanged with result.
REQ-010 kill  input  1  abort in-flight operation.
REQ-011 resp_valid  output  1; resp_ready  input  1; resp_data  output  XLEN; resp_tag  output  TAG_W.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States IDLE, MUL, DIV, FIX, DONE; state register one-hot or encoded, implementer's choice.
REQ-014 req_ready = (state==IDLE) & ~kill; the accept cycle latches op, operands, tag.
REQ-015 IDLE->MUL on accepted op 0-3; IDLE->DIV on accepted op 4-7.
REQ-016 MUL: one cycle, 33x33 signed product of sign/zero-extended operands (MULH both signed, MULHSU a signed/b unsigned, MULHU both unsigned); MUL returns product[31:0], others product[63:32]; result registered; MUL->DONE.
REQ-017 Multiply latency: accepted at edge N, resp_valid high after edge N+2.
REQ-018 DIV: operands converted to magnitudes (signed ops only); 32 restoring iterations, one quotient bit per cycle, 6-bit counter 0..31; counter==31 -> FIX.
REQ-019 FIX: quotient negated iff signed op, signs differ, and divisor != 0; remainder negated iff signed op and dividend negative; FIX->DONE.
REQ-020 Divide latency: accepted at edge N, resp_valid high after edge N+34.
REQ-021 Divide by zero: quotient 0xFFFFFFFF (all variants), remainder = req_a.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0; no special-casing required, falls out of REQ-018/019.
REQ-023 DONE: resp_valid high; resp_data/resp_tag held stable until resp_ready; handshake moves DONE->IDLE; earliest next accept one cycle later.
REQ-024 kill in MUL, DIV or FIX: next state IDLE, no response; kill in DONE: response dropped, next state IDLE; kill in IDLE: req_ready low, nothing accepted.
REQ-025 kill and resp_ready together in DONE: kill wins, result counted as dropped.
REQ-026 Outputs are registered; no combinational path req_* -> resp_*.

Reset
REQ-027 reset: state IDLE, counter 0, resp_valid 0, resp_data 0, resp_tag 0, busy 0; req_ready high first cycle after reset deassertion.
REQ-028 reset mid-operation abandons work; no response issued.

Configuration
REQ-029 Macro MULDIV_DIV_EARLY_OUT_EN: when defined, accepted divide with req_b==0 goes IDLE->FIX directly, resp_valid after edge N+2, results per REQ-021.
REQ-030 Without MULDIV_DIV_EARLY_OUT_EN, divide-by-zero takes the full REQ-020 latency with identical results.

Structure
REQ-031 Package muldiv_pkg holds: XLEN, op encodings (funct3 localparams), state enum, DIV_ITERS=32.
REQ-032 Sub-module muldiv_div_step: combinational single restoring iteration (remainder, quotient, divisor in; next remainder, quotient out), instanced once.

Verification
REQ-033 MULH a=0x80000000 b=0x80000000 -> resp_data 0x40000000, resp_valid exactly 2 cycles after accept.
REQ-034 DIV a=0xFFFFFFF9 (-7) b=2 -> quotient 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; latency 34.
REQ-035 DIVU a=5 b=0 -> 0xFFFFFFFF, REMU -> 5; latency 34 without macro, 2 with MULDIV_DIV_EARLY_OUT_EN.
REQ-036 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-037 Divide started, kill at cycle 10 -> no resp_valid, busy low next cycle, new MUL accepted; reset at cycle 5 of a divide -> same outcome.
REQ-038 DONE with resp_ready low 8 cycles -> resp_data/resp_tag stable, req_ready low throughout; handshake on cycle 9 -> IDLE.
